dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised data memory with integrated load/store unit for the 5-stage pipeline's MEM stage. It replaces the flat word-only data memory and serves the EX/MEM request stream. It adds byte and halfword accesses with RV32I sign/zero extension, a synchronous read port, address-range and alignment checking, and a valid/ready request handshake. It optionally supports hardware splitting of misaligned accesses into two word accesses.

## Interface
Parameters:
- DEPTH, 1024: memory size in 32-bit words; must be a power of two ≥ 2.
- INIT_FILE, "data.hex": hex image loaded by $readmemh at time zero; empty string skips loading.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- rsp_valid  out  1  one-cycle pulse per accepted request; no back-pressure.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid; illegal funct3, out-of-range, or unsupported misalignment.

## Operation
- Range: the address is legal when req_addr < DEPTH*4. Bits above that are not wrapped; an address ≥ DEPTH*4 is an error.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; byte is always aligned.
- Error request: no memory write, rsp_err=1, rsp_rdata=0. Errors are fully checked at accept, before any write.
- Store: byte enables come from size and addr[1:0]; wdata is lane-shifted; only the enabled bytes are written at the accept edge.
- Load: the word is read at the accept edge, then lane-selected by addr[1:0] and extended per funct3 (lb/lh sign-extend, lbu/lhu zero-extend).
- Memory contents are not cleared by reset; only control state and outputs reset.
- FSM states: IDLE (req_ready=1), SPLIT (req_ready=0; exists only with DMEM_SPLIT_EN).
  - IDLE → SPLIT on accepting a misaligned request.
  - SPLIT → IDLE after one cycle.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE.

## Timing
- Aligned or error request accepted at edge N: rsp_valid/rsp_rdata/rsp_err are valid in cycle N+1, registered.
- Throughput is one request per cycle.
- Back-to-back store then load to the same word: the load observes the stored bytes (write at edge N, read at edge N+1).
- Split request accepted at edge N:
  - Low word handled at edge N, high word (addr+4 word) at edge N+1.
  - Response in cycle N+2; req_ready=0 during cycle N+1.
- rst_n asserted mid-split: the FSM returns to IDLE immediately and no response is produced. An already-written low half remains; the high half is not written.
- rst_n is asserted asynchronously and deasserts synchronously to clk via an internal two-flop synchroniser.

## Configuration
- DMEM_SPLIT_EN defined: misaligned lh/lhu/lw/sh/sw are performed as two word accesses, with bytes merged or written across the boundary.
  - If the second word is out of range (≥ DEPTH*4), the request errors with no write to either word.
- DMEM_SPLIT_EN undefined: misaligned requests return rsp_err=1 in N+1 with no write. The SPLIT state and the second-word datapath are absent, and req_ready is constant 1 after reset.

## Test plan
- Reset: hold rst_n=0 → req_ready=1, rsp_valid=0; memory preloaded from INIT_FILE is unchanged after reset release.
- Byte/half extension: sw 0x8000_80F0 to addr 0x10 →
  - lb 0x10 returns 0xFFFF_FFF0; lbu 0x10 returns 0x0000_00F0.
  - lh 0x12 returns 0xFFFF_8000; lhu 0x12 returns 0x0000_8000.
- Byte enables: sw 0x1122_3344 @0x20, then sb 0xAA @0x21 → lw 0x20 returns 0x1122_AA44; back-to-back store→load issued on consecutive cycles.
- Errors (DEPTH=1024):
  - lw 0x1000 → rsp_err=1, rdata=0.
  - funct3=011 → rsp_err=1.
  - sw 0x1000 leaves all memory unchanged.
- Misaligned with DMEM_SPLIT_EN:
  - sw 0x1122_3344 @0x0, sw 0x5566_7788 @0x4, lw 0x3 → rdata 0x6677_8811, response 2 cycles after accept, req_ready low for one cycle.
  - sh @0xFFF → rsp_err=1, no write.
- Misaligned without DMEM_SPLIT_EN: lw 0x3 → rsp_err=1 in the next cycle; sh 0xBEEF @0x1 leaves word 0 unchanged.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: data memory with integrated load/store unit for the MEM stage.
// Byte/halfword/word loads and stores with RV32I extension, synchronous read,
// range and alignment checking, and a valid/ready request handshake.
// Optional feature macro: DMEM_SPLIT_EN -- misaligned halfword/word accesses
// are performed as two word accesses over consecutive cycles.
module dmem_lsu #(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "data.hex"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Reset synchroniser: asynchronous assert, synchronous release
    // ------------------------------------------------------------------
    logic rst_meta_n;
    logic rst_sync_n;

    // Two-flop release of the internal reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [1:0]    off;
    logic [3:0]    size_be;
    logic          f3_ok;
    logic          misal;
    logic          in_range;
    logic [AW-1:0] lo_idx;
    logic [3:0]    be_lo;
    logic [31:0]   wd_lo;
    logic          err;
    logic          go_split;
    logic          accept;

    assign off      = req_addr[1:0];
    assign lo_idx   = req_addr[AW+1:2];
    assign in_range = (req_addr >> (AW + 2)) == 32'd0;

    // Size, legality and alignment of the incoming request.
    always_comb begin
        size_be = 4'b1111;
        f3_ok   = 1'b0;
        misal   = 1'b0;
        case (req_funct3[1:0])
            2'b00:   size_be = 4'b0001;
            2'b01:   size_be = 4'b0011;
            default: size_be = 4'b1111;
        endcase
        if (req_write)
            f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
        else
            f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
        if (req_funct3[1:0] == 2'b01)
            misal = off[0];
        else if (req_funct3[1:0] == 2'b10)
            misal = (off != 2'b00);
    end

`ifdef DMEM_SPLIT_EN
    typedef enum logic {IDLE, SPLIT} state_t;
    state_t state, state_nxt;

    logic [7:0]    be64;
    logic [63:0]   wd64;
    logic [AW-1:0] hi_idx;
    logic          hi_need;
    logic          hi_oob;

    // Lanes are laid out over two words so a crossing access splits naturally.
    assign be64    = {4'b0000, size_be} << off;
    assign wd64    = {32'd0, req_wdata} << {off, 3'b000};
    assign be_lo   = be64[3:0];
    assign wd_lo   = wd64[31:0];
    assign hi_idx  = lo_idx + AW'(1);
    assign hi_need = |be64[7:4];
    assign hi_oob  = (lo_idx == AW'(DEPTH - 1));
    // Any misaligned access takes the two-cycle path so its latency is fixed;
    // only one that really touches the next word can fail on its range.
    assign err      = !f3_ok || !in_range || (misal && hi_need && hi_oob);
    assign go_split = !err && misal;
    assign req_ready = (state == IDLE);
`else
    assign be_lo     = size_be << off;
    assign wd_lo     = req_wdata << {off, 3'b000};
    assign err       = !f3_ok || !in_range || misal;
    assign go_split  = 1'b0;
    assign req_ready = 1'b1;
`endif

    assign accept = req_valid && req_ready && rst_sync_n;

`ifdef DMEM_SPLIT_EN
    // Second-word request context held across the split cycle.
    logic [AW-1:0] hi_idx_q;
    logic [3:0]    hi_be_q;
    logic [31:0]   hi_wd_q;
    logic          hi_write_q;
    logic [31:0]   rd_lo_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) state <= IDLE;
        else             state <= state_nxt;
    end

    // FSM next state: a split occupies exactly one extra cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && go_split) state_nxt = SPLIT;
            SPLIT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Single memory port: request word on accept, next word in SPLIT
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [AW-1:0] rd_idx;
    logic          rd_en;
    logic [31:0]   rd_q;

    // Port address/enable selection.
    always_comb begin
        wr_idx  = lo_idx;
        wr_be   = '0;
        wr_data = wd_lo;
        rd_idx  = lo_idx;
        rd_en   = accept && !req_write;
        if (accept && !err && req_write) wr_be = be_lo;
`ifdef DMEM_SPLIT_EN
        if (state == SPLIT) begin
            wr_idx  = hi_idx_q;
            wr_data = hi_wd_q;
            wr_be   = hi_write_q ? hi_be_q : 4'b0000;
            rd_idx  = hi_idx_q;
            rd_en   = !hi_write_q;
        end
`endif
    end

    // Byte-enabled write and registered read (read returns the old word).
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
        if (rd_en) rd_q <= mem[rd_idx];
    end

`ifdef DMEM_SPLIT_EN
    // Capture second-word context and park the low read word during SPLIT.
    always_ff @(posedge clk) begin
        if (accept) begin
            hi_idx_q   <= hi_idx;
            hi_be_q    <= be64[7:4];
            hi_wd_q    <= wd64[63:32];
            hi_write_q <= req_write;
        end
        if (state == SPLIT) rd_lo_q <= rd_q;
    end
`endif

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    logic       rsp_valid_q;
    logic       rsp_err_q;
    logic       rsp_load_q;
    logic [2:0] rsp_f3_q;
    logic [1:0] rsp_off_q;
    logic       rsp_split_q;

    // Response control: one pulse per request, one cycle later for splits.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_f3_q    <= '0;
            rsp_off_q   <= '0;
            rsp_split_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
                rsp_valid_q <= !go_split;
                rsp_err_q   <= err;
                rsp_load_q  <= !req_write;
                rsp_f3_q    <= req_funct3;
                rsp_off_q   <= off;
                rsp_split_q <= go_split;
            end
`ifdef DMEM_SPLIT_EN
            else if (state == SPLIT) begin
                rsp_valid_q <= 1'b1;
            end
`endif
        end
    end

    logic [31:0] lane;
    logic [31:0] ext;

    // Lane select and RV32I extension of the read data.
    always_comb begin
`ifdef DMEM_SPLIT_EN
        logic [63:0] word64;
        word64 = rsp_split_q ? {rd_q, rd_lo_q} : {32'd0, rd_q};
        lane   = word64[{rsp_off_q, 3'b000} +: 32];
`else
        lane   = rd_q >> {rsp_off_q, 3'b000};
`endif
        case (rsp_f3_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'd0, lane[7:0]};
            3'b101:  ext = {16'd0, lane[15:0]};
            default: ext = lane;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q && rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && rsp_load_q && !rsp_err_q && !rsp_split_q) ? ext :
                       (rsp_valid_q && rsp_load_q && !rsp_err_q)                 ? ext : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed scoreboard bench for dmem_lsu (DEPTH=1024, no preload).
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

`ifdef DMEM_SPLIT_EN
    localparam bit SPL = 1'b1;
`else
    localparam bit SPL = 1'b0;
`endif
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    dmem_lsu #(.DEPTH(1024), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned neg_cnt = 0;
    int unsigned last_waits = 0;

    string       qn[$];
    logic [31:0] qr[$];
    logic        qe[$];
    int unsigned qd[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pop the oldest expectation whenever a response appears.
    always @(negedge clk) begin
        neg_cnt++;
        if (rsp_valid === 1'b1) begin
            if (qr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response", rsp_rdata, rsp_err);
            end else begin
                string       nm;
                logic [31:0] er;
                logic        ee;
                int unsigned ed;
                nm = qn.pop_front(); er = qr.pop_front(); ee = qe.pop_front(); ed = qd.pop_front();
                chk({nm, ".rdata"}, rsp_rdata, er);
                chk({nm, ".err"}, 32'(rsp_err), 32'(ee));
                chk({nm, ".cycle"}, neg_cnt, ed);
            end
        end
    end

    // Drive one request; expectation is due 'lat' falling edges after acceptance.
    task automatic issue(input string nm, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rd,
                         input int unsigned lat, input bit want);
        @(negedge clk); #1;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        last_waits = 0;
        while (req_ready !== 1'b1 && last_waits < 20) begin
            @(negedge clk); #1;
            last_waits++;
        end
        if (req_ready !== 1'b1) begin
            chk({nm, ".ready_timeout"}, 32'(req_ready), 32'd1);
        end else if (want) begin
            qn.push_back(nm); qr.push_back(e_rd); qe.push_back(e_err); qd.push_back(neg_cnt + lat);
        end
    endtask

    task automatic st(input string nm, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic e_err, input int unsigned lat);
        issue(nm, 1'b1, f3, a, wd, e_err, 32'd0, lat, 1'b1);
    endtask

    task automatic ld(input string nm, input logic [2:0] f3, input logic [31:0] a,
                      input logic e_err, input logic [31:0] e_rd, input int unsigned lat);
        issue(nm, 1'b0, f3, a, 32'd0, e_err, e_rd, lat, 1'b1);
    endtask

    task automatic idle();
        @(negedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic reset_checks(input string nm);
        chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
        chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, ".rsp_rdata"}, rsp_rdata, 32'd0);
        chk({nm, ".rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lm;
        lm = SPL ? 2 : 1;

        repeat (3) @(negedge clk);
        #1;
        reset_checks("reset0");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Extension of byte and halfword loads.
        st("sw10", LW, 32'h10, 32'h8000_80F0, 1'b0, 1);
        ld("lb10", LB, 32'h10, 1'b0, 32'hFFFF_FFF0, 1);
        ld("lbu10", LBU, 32'h10, 1'b0, 32'h0000_00F0, 1);
        ld("lh12", LH, 32'h12, 1'b0, 32'hFFFF_8000, 1);
        ld("lhu12", LHU, 32'h12, 1'b0, 32'h0000_8000, 1);
        ld("lw10", LW, 32'h10, 1'b0, 32'h8000_80F0, 1);

        // Byte enables, back-to-back store then load.
        st("sw20", LW, 32'h20, 32'h1122_3344, 1'b0, 1);
        st("sb21", LB, 32'h21, 32'h5555_55AA, 1'b0, 1);
        ld("lw20", LW, 32'h20, 1'b0, 32'h1122_AA44, 1);

        // Range and funct3 errors.
        st("swFFC", LW, 32'hFFC, 32'h1357_9BDF, 1'b0, 1);
        st("sw0", LW, 32'h0, 32'h2468_ACE0, 1'b0, 1);
        st("sw1000", LW, 32'h1000, 32'hDEAD_BEEF, 1'b1, 1);
        ld("lw0_a", LW, 32'h0, 1'b0, 32'h2468_ACE0, 1);
        ld("lwFFC_a", LW, 32'hFFC, 1'b0, 32'h1357_9BDF, 1);
        ld("lw1000", LW, 32'h1000, 1'b1, 32'h0, 1);
        ld("ld_f3_011", 3'b011, 32'h0, 1'b1, 32'h0, 1);
        st("st_f3_011", 3'b011, 32'h0, 32'hFFFF_FFFF, 1'b1, 1);
        st("st_f3_100", 3'b100, 32'h0, 32'hFFFF_FFFF, 1'b1, 1);
        ld("lw0_b", LW, 32'h0, 1'b0, 32'h2468_ACE0, 1);
        ld("lhFFE", LH, 32'hFFE, 1'b0, 32'h0000_1357, 1);
        ld("lbFFF", LB, 32'hFFF, 1'b0, 32'h0000_0013, 1);
        ld("lbFFC", LB, 32'hFFC, 1'b0, 32'hFFFF_FFDF, 1);
        ld("lbuFFC", LBU, 32'hFFC, 1'b0, 32'h0000_00DF, 1);

        // Misaligned accesses.
        st("sw0_m", LW, 32'h0, 32'h1122_3344, 1'b0, 1);
        st("sw4_m", LW, 32'h4, 32'h5566_7788, 1'b0, 1);
        ld("lw3", LW, 32'h3, !SPL, SPL ? 32'h6677_8811 : 32'h0, lm);
        st("sh1", LH, 32'h1, 32'h0000_BEEF, !SPL, lm);
        chk("ready_low_after_split", last_waits, SPL ? 32'd1 : 32'd0);
        ld("lw0_m", LW, 32'h0, 1'b0, SPL ? 32'h11BE_EF44 : 32'h1122_3344, 1);
`ifdef DMEM_SPLIT_EN
        st("sh3", LH, 32'h3, 32'h0000_BEEF, 1'b0, 2);
        ld("lw0_s", LW, 32'h0, 1'b0, 32'hEFBE_EF44, 1);
        ld("lw4_s", LW, 32'h4, 1'b0, 32'h5566_77BE, 1);
        ld("lh3", LH, 32'h3, 1'b0, 32'hFFFF_BEEF, 2);
        ld("lhu3", LHU, 32'h3, 1'b0, 32'h0000_BEEF, 2);
        st("sw8", LW, 32'h8, 32'h9999_9999, 1'b0, 1);
        st("sw6", LW, 32'h6, 32'hA0B0_C0D0, 1'b0, 2);
        ld("lw4_t", LW, 32'h4, 1'b0, 32'hC0D0_77BE, 1);
        ld("lw8_t", LW, 32'h8, 1'b0, 32'h9999_A0B0, 1);
        ld("lw6", LW, 32'h6, 1'b0, 32'hA0B0_C0D0, 2);
        st("shFFF", LH, 32'hFFF, 32'h0000_7777, 1'b1, 1);
        ld("lwFFD", LW, 32'hFFD, 1'b1, 32'h0, 1);
        ld("lwFFC_s", LW, 32'hFFC, 1'b0, 32'h1357_9BDF, 1);

        // Reset during the split cycle: low half stays written, no response.
        st("sw30", LW, 32'h30, 32'h0000_0000, 1'b0, 1);
        st("sw34", LW, 32'h34, 32'h1111_1111, 1'b0, 1);
        idle();
        repeat (2) @(negedge clk);
        issue("sw32_rst", 1'b1, LW, 32'h32, 32'hA1B2_C3D4, 1'b0, 32'h0, 2, 1'b0);
        @(negedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        ld("lw30_r", LW, 32'h30, 1'b0, 32'hC3D4_0000, 1);
        ld("lw34_r", LW, 32'h34, 1'b0, 32'h1111_1111, 1);
`endif

        // Memory contents survive reset.
        st("sw40", LW, 32'h40, 32'hCAFE_BABE, 1'b0, 1);
        idle();
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset_checks("reset1");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        ld("lw40", LW, 32'h40, 1'b0, 32'hCAFE_BABE, 1);

        idle();
        repeat (10) @(negedge clk);
        #1;
        chk("drain", 32'(qr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
